// File: rtl/feature_scan_controller.sv
// Walks every (node, feature) pair in row-major order over a valid/ready
// handshake, flags the last feature / last pair, then pulses done.
module feature_scan_controller #(
  parameter int FEATURE_LAST = 3,
  parameter int NODE_LAST    = 3,
  parameter int FW = (FEATURE_LAST > 0) ? $clog2(FEATURE_LAST + 1) : 1,
  parameter int NW = (NODE_LAST > 0) ? $clog2(NODE_LAST + 1) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [NW-1:0] node_idx,
  output logic [FW-1:0] feature_idx,
  output logic          last_feature,
  output logic          last_pair,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [FW-1:0] FEAT_MAX = FW'(FEATURE_LAST);
  localparam logic [NW-1:0] NODE_MAX = NW'(NODE_LAST);

  state_t        state_q, state_d;
  logic [FW-1:0] feat_q, feat_d;
  logic [NW-1:0] node_q, node_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      feat_q  <= '0;
      node_q  <= '0;
    end else begin
      state_q <= state_d;
      feat_q  <= feat_d;
      node_q  <= node_d;
    end
  end

  always_comb begin
    state_d = state_q;
    feat_d  = feat_q;
    node_d  = node_q;
    case (state_q)
      IDLE: begin
        // abort wins over a simultaneous start
        if (start && !abort) begin
          state_d = SCAN;
          feat_d  = '0;
          node_d  = '0;
        end
      end
      SCAN: begin
        if (abort) begin
          state_d = IDLE;
          feat_d  = '0;
          node_d  = '0;
        end else if (out_ready) begin
          if (feat_q < FEAT_MAX) begin
            feat_d = feat_q + 1'b1;
          end else begin
            feat_d = '0;
            if (node_q < NODE_MAX) begin
              node_d = node_q + 1'b1;
            end else begin
              node_d  = '0;
              state_d = DONE;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        feat_d  = '0;
        node_d  = '0;
      end
    endcase
  end

  always_comb begin
    out_valid    = (state_q == SCAN);
    busy         = (state_q == SCAN);
    done         = (state_q == DONE);
    node_idx     = node_q;
    feature_idx  = feat_q;
    last_feature = out_valid && (feat_q == FEAT_MAX);
    last_pair    = last_feature && (node_q == NODE_MAX);
  end

endmodule
